card_board: RTL and testbench

Card board storage and click responder for the memory game: the receiving end of the game controller's card-write interface and the originating end of its card-click interface. Holds per-card state and color. Applies state writes from the controller. Publishes a double-buffered snapshot to the renderer on `update_cards_en`. Converts mouse clicks into single-cycle `card_pressed` reports through a sequential grid hit-test scan.

---
 rtl/card_board.sv | 192 +++++++++++++++++++
 tb/tb_card_board.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_board.sv
// Card board storage (working/snapshot state and color arrays) plus the grid hit-test click responder.
// Optional click lockout after each report: define CARD_CLICK_GUARD_EN.
module card_board #(
    parameter int unsigned GRID_X0      = 64,
    parameter int unsigned GRID_Y0      = 48,
    parameter int unsigned CARD_W       = 100,
    parameter int unsigned CARD_H       = 80,
    parameter int unsigned GAP          = 16,
    parameter int unsigned COLS         = 4,
    parameter int unsigned GUARD_CYCLES = 13_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  num_of_cards,
    input  logic        board_init,
    input  logic        color_wr_en,
    input  logic [4:0]  color_wr_addr,
    input  logic [11:0] color_wr_data,
    input  logic        write_card_en,
    input  logic [1:0]  write_card_state,
    input  logic [4:0]  write_card_address,
    input  logic        update_cards_en,
    input  logic        wait_for_click_en,
    input  logic        mouse_left,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [4:0]  draw_addr,
    output logic [1:0]  draw_state,
    output logic [11:0] draw_color,
    output logic        card_pressed,
    output logic [4:0]  card_clicked_address,
    output logic [11:0] card_clicked_color
);

    localparam int         NUM_SLOTS  = 32;
    localparam logic [1:0] ST_ABSENT  = 2'b00;
    localparam logic [1:0] ST_COVERED = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REPORT} click_state_e;

    logic [1:0]  work_state [NUM_SLOTS];
    logic [11:0] work_color [NUM_SLOTS];
    logic [1:0]  snap_state [NUM_SLOTS];
    logic [11:0] snap_color [NUM_SLOTS];
    logic [1:0]  state_d    [NUM_SLOTS];
    logic [11:0] color_d    [NUM_SLOTS];

    // Next-cycle working arrays; the snapshot copies these so a same-cycle write is published.
    always_comb begin
        state_d = work_state;
        color_d = work_color;
        if (board_init) begin
            for (int i = 0; i < NUM_SLOTS; i++)
                state_d[i] = (6'(i) < num_of_cards) ? ST_COVERED : ST_ABSENT;
        end else if (write_card_en && ({1'b0, write_card_address} < num_of_cards)) begin
            state_d[write_card_address] = write_card_state;
        end
        if (color_wr_en)
            color_d[color_wr_addr] = color_wr_data;
    end

    // NOTE: the card arrays are small register files that must read as zero after reset,
    // so they are reset explicitly rather than inferred as RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                work_state[i] <= '0;
                work_color[i] <= '0;
                snap_state[i] <= '0;
                snap_color[i] <= '0;
            end
            draw_state <= '0;
            draw_color <= '0;
        end else begin
            work_state <= state_d;
            work_color <= color_d;
            if (update_cards_en) begin
                snap_state <= state_d;
                snap_color <= color_d;
            end
            draw_state <= snap_state[draw_addr];
            draw_color <= snap_color[draw_addr];
        end
    end

    click_state_e click_q, click_d;
    logic         mouse_q;
    logic [11:0]  x_q, y_q;
    logic [12:0]  rx_q, ry_q;
    logic [4:0]   idx_q;
    logic [4:0]   col_q;
    logic         guard_clear;
    logic         accept;
    logic         hit;
    logic         last;

`ifdef CARD_CLICK_GUARD_EN
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    logic [GW-1:0] guard_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            guard_cnt <= '0;
        else if (board_init)
            guard_cnt <= '0;
        else if (click_q == S_REPORT)
            guard_cnt <= GW'(GUARD_CYCLES);
        else if (guard_cnt != '0)
            guard_cnt <= guard_cnt - 1'b1;
    end

    assign guard_clear = (guard_cnt == '0);
`else
    assign guard_clear = 1'b1;
`endif

    assign accept = mouse_left && !mouse_q && wait_for_click_en && guard_clear;
    assign hit    = ({1'b0, x_q} >= rx_q) && ({1'b0, x_q} <= rx_q + 13'(CARD_W - 1)) &&
                    ({1'b0, y_q} >= ry_q) && ({1'b0, y_q} <= ry_q + 13'(CARD_H - 1));
    assign last   = (({1'b0, idx_q} + 6'd1) >= num_of_cards) || (idx_q == 5'd31);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            click_q <= S_IDLE;
        else
            click_q <= click_d;
    end

    always_comb begin
        click_d = click_q;
        case (click_q)
            S_IDLE:   if (accept) click_d = S_SCAN;
            S_SCAN: begin
                if (!wait_for_click_en || num_of_cards == 6'd0)
                    click_d = S_IDLE;
                else if (hit)
                    click_d = (work_state[idx_q] == ST_COVERED) ? S_REPORT : S_IDLE;
                else if (last)
                    click_d = S_IDLE;
            end
            S_REPORT: click_d = S_IDLE;
            default:  click_d = S_IDLE;
        endcase
    end

    // Scan walks the grid incrementally: one card rectangle per cycle, no multiply.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mouse_q              <= 1'b0;
            x_q                  <= '0;
            y_q                  <= '0;
            rx_q                 <= '0;
            ry_q                 <= '0;
            idx_q                <= '0;
            col_q                <= '0;
            card_pressed         <= 1'b0;
            card_clicked_address <= '0;
            card_clicked_color   <= '0;
        end else begin
            mouse_q      <= mouse_left;
            card_pressed <= 1'b0;
            case (click_q)
                S_IDLE: if (accept) begin
                    x_q   <= xpos;
                    y_q   <= ypos;
                    idx_q <= '0;
                    col_q <= '0;
                    rx_q  <= 13'(GRID_X0);
                    ry_q  <= 13'(GRID_Y0);
                end
                S_SCAN: if (!hit) begin
                    idx_q <= idx_q + 5'd1;
                    if (col_q == 5'(COLS - 1)) begin
                        col_q <= '0;
                        rx_q  <= 13'(GRID_X0);
                        ry_q  <= ry_q + 13'(CARD_H + GAP);
                    end else begin
                        col_q <= col_q + 5'd1;
                        rx_q  <= rx_q + 13'(CARD_W + GAP);
                    end
                end
                S_REPORT: begin
                    card_pressed         <= 1'b1;
                    card_clicked_address <= idx_q;
                    card_clicked_color   <= work_color[idx_q];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_card_board.sv
// Self-checking bench for card_board: array init/write/snapshot paths and the click scan,
// with expected click reports queued at stimulus time and matched when card_pressed fires.
module tb_card_board;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  num_of_cards;
    logic        board_init;
    logic        color_wr_en;
    logic [4:0]  color_wr_addr;
    logic [11:0] color_wr_data;
    logic        write_card_en;
    logic [1:0]  write_card_state;
    logic [4:0]  write_card_address;
    logic        update_cards_en;
    logic        wait_for_click_en;
    logic        mouse_left;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [4:0]  draw_addr;
    logic [1:0]  draw_state;
    logic [11:0] draw_color;
    logic        card_pressed;
    logic [4:0]  card_clicked_address;
    logic [11:0] card_clicked_color;

    card_board #(.GUARD_CYCLES(10)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .num_of_cards        (num_of_cards),
        .board_init          (board_init),
        .color_wr_en         (color_wr_en),
        .color_wr_addr       (color_wr_addr),
        .color_wr_data       (color_wr_data),
        .write_card_en       (write_card_en),
        .write_card_state    (write_card_state),
        .write_card_address  (write_card_address),
        .update_cards_en     (update_cards_en),
        .wait_for_click_en   (wait_for_click_en),
        .mouse_left          (mouse_left),
        .xpos                (xpos),
        .ypos                (ypos),
        .draw_addr           (draw_addr),
        .draw_state          (draw_state),
        .draw_color          (draw_color),
        .card_pressed        (card_pressed),
        .card_clicked_address(card_clicked_address),
        .card_clicked_color  (card_clicked_color)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [11:0] color;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [1:0]  st_m  [32];
    logic [11:0] col_m [32];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && card_pressed) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse addr=%0d cyc=%0d", card_clicked_address, cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if (cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL pulse_cycle got=%0d exp=%0d", cyc, e.cyc);
                end
                checks++;
                if (card_clicked_address !== e.addr) begin
                    failures++;
                    $display("FAIL pulse_addr got=%0d exp=%0d", card_clicked_address, e.addr);
                end
                checks++;
                if (card_clicked_color !== e.color) begin
                    failures++;
                    $display("FAIL pulse_color got=%h exp=%h", card_clicked_color, e.color);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            st_m[i]  = 2'b00;
            col_m[i] = 12'h000;
        end
    endtask

    task automatic do_init(input int n);
        @(negedge clk);
        num_of_cards = 6'(n);
        board_init   = 1'b1;
        @(negedge clk);
        board_init   = 1'b0;
        for (int i = 0; i < 32; i++) st_m[i] = (i < n) ? 2'b01 : 2'b00;
    endtask

    task automatic do_write(input int a, input logic [1:0] s);
        @(negedge clk);
        write_card_en      = 1'b1;
        write_card_address = 5'(a);
        write_card_state   = s;
        @(negedge clk);
        write_card_en      = 1'b0;
        if (a < int'(num_of_cards)) st_m[a] = s;
    endtask

    task automatic do_update();
        @(negedge clk);
        update_cards_en = 1'b1;
        @(negedge clk);
        update_cards_en = 1'b0;
    endtask

    task automatic load_colors();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            color_wr_en   = 1'b1;
            color_wr_addr = 5'(i);
            color_wr_data = 12'($urandom_range(4095));
            col_m[i]      = color_wr_data;
        end
        @(negedge clk);
        color_wr_en = 1'b0;
    endtask

    task automatic read_draw(input int a, output logic [1:0] s, output logic [11:0] c);
        @(negedge clk);
        draw_addr = 5'(a);
        @(negedge clk);
        s = draw_state;
        c = draw_color;
    endtask

    // One-cycle click; k >= 0 queues a report for card k at edge cycle + 3 + k.
    task automatic click(input int x, input int y, input int k);
        @(negedge clk);
        xpos       = 12'(x);
        ypos       = 12'(y);
        mouse_left = 1'b1;
        if (k >= 0) sb.push_back('{5'(k), col_m[k], cyc + 3 + k});
        @(negedge clk);
        mouse_left = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (40) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s missing_pulses got=0 exp=%0d", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        logic [1:0]  s;
        logic [11:0] c;
        checks++;
        if (card_pressed !== 1'b0) begin
            failures++;
            $display("FAIL reset_pressed got=%b exp=0", card_pressed);
        end
        checks++;
        if (card_clicked_address !== 5'd0 || card_clicked_color !== 12'h000) begin
            failures++;
            $display("FAIL reset_click_out got=%0d/%h exp=0/000", card_clicked_address, card_clicked_color);
        end
        read_draw(9, s, c);
        checks++;
        if (s !== 2'b00 || c !== 12'h000) begin
            failures++;
            $display("FAIL reset_draw got=%b/%h exp=00/000", s, c);
        end
    endtask

    task automatic test_init();
        logic [1:0]  s;
        logic [11:0] c;
        do_init(16);
        do_update();
        for (int i = 0; i < 32; i++) begin
            read_draw(i, s, c);
            checks++;
            if (s !== st_m[i]) begin
                failures++;
                $display("FAIL init_state[%0d] got=%b exp=%b", i, s, st_m[i]);
            end
        end
    endtask

    task automatic test_colors();
        logic [1:0]  s;
        logic [11:0] c;
        load_colors();
        do_update();
        for (int i = 0; i < 32; i += 5) begin
            read_draw(i, s, c);
            checks++;
            if (c !== col_m[i]) begin
                failures++;
                $display("FAIL color[%0d] got=%h exp=%h", i, c, col_m[i]);
            end
        end
    endtask

    task automatic test_hit();
        click(200, 160, 5);
        drain("hit_card5");
    endtask

    task automatic test_gaps();
        click(170, 60, -1);
        drain("gap");
        do_write(0, 2'b10);
        click(64, 48, -1);
        drain("matched_card");
        do_write(0, 2'b01);
        click(163, 127, 0);
        drain("corner_card0");
    endtask

    task automatic test_ignored();
        logic [1:0]  s;
        logic [11:0] c;
        wait_for_click_en = 1'b0;
        click(200, 160, -1);
        drain("wfc_low");
        wait_for_click_en = 1'b1;
        click(420, 340, -1);
        repeat (2) @(negedge clk);
        wait_for_click_en = 1'b0;
        @(negedge clk);
        wait_for_click_en = 1'b1;
        drain("wfc_drop");
        do_write(20, 2'b11);
        do_write(7, 2'b11);
        do_write(3, 2'b11);
        @(negedge clk);
        board_init         = 1'b1;
        write_card_en      = 1'b1;
        write_card_address = 5'd3;
        write_card_state   = 2'b10;
        @(negedge clk);
        board_init    = 1'b0;
        write_card_en = 1'b0;
        for (int i = 0; i < 32; i++) st_m[i] = (i < 16) ? 2'b01 : 2'b00;
        do_write(7, 2'b11);
        do_update();
        read_draw(20, s, c);
        checks++;
        if (s !== 2'b00) begin
            failures++;
            $display("FAIL write_out_of_range got=%b exp=00", s);
        end
        read_draw(7, s, c);
        checks++;
        if (s !== st_m[7]) begin
            failures++;
            $display("FAIL write_in_range got=%b exp=%b", s, st_m[7]);
        end
        read_draw(3, s, c);
        checks++;
        if (s !== st_m[3]) begin
            failures++;
            $display("FAIL init_beats_write got=%b exp=%b", s, st_m[3]);
        end
    endtask

    task automatic test_reset_midscan();
        click(200, 160, 5);
        drain("pre_reset_hit");
        @(negedge clk);
        draw_addr = 5'd5;
        click(420, 340, -1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (card_pressed !== 1'b0 || card_clicked_address !== 5'd0 || card_clicked_color !== 12'h000 ||
            draw_state !== 2'b00 || draw_color !== 12'h000) begin
            failures++;
            $display("FAIL reset_midscan_outputs got=%b/%0d/%h/%b/%h exp=0/0/000/00/000",
                     card_pressed, card_clicked_address, card_clicked_color, draw_state, draw_color);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drain("reset_midscan");
    endtask

    task automatic test_back_to_back();
        int p;
        int t;
        do_init(16);
        load_colors();
        click(100, 100, 0);
        t = 0;
        while (!card_pressed && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 50) begin
            failures++;
            $display("FAIL guard_first_pulse got=timeout exp=pulse");
        end
        p = cyc;
        while (cyc < p + 5) @(negedge clk);
        xpos       = 12'd100;
        ypos       = 12'd100;
        mouse_left = 1'b1;
`ifndef CARD_CLICK_GUARD_EN
        sb.push_back('{5'd0, col_m[0], cyc + 3});
`endif
        @(negedge clk);
        mouse_left = 1'b0;
        while (cyc < p + 12) @(negedge clk);
        mouse_left = 1'b1;
        sb.push_back('{5'd0, col_m[0], cyc + 3});
        @(negedge clk);
        mouse_left = 1'b0;
        drain("back_to_back");
    endtask

    initial begin
        rst                = 1'b0;
        num_of_cards       = 6'd0;
        board_init         = 1'b0;
        color_wr_en        = 1'b0;
        color_wr_addr      = '0;
        color_wr_data      = '0;
        write_card_en      = 1'b0;
        write_card_state   = '0;
        write_card_address = '0;
        update_cards_en    = 1'b0;
        wait_for_click_en  = 1'b1;
        mouse_left         = 1'b0;
        xpos               = '0;
        ypos               = '0;
        draw_addr          = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;

        test_reset();
        test_init();
        test_colors();
        test_hit();
        test_gaps();
        test_ignored();
        test_reset_midscan();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
